// File: rtl/slv_guard_rst_ctrl_if.sv
// Bundle between the slave guard, the reset sequencer and the subordinate.
// The sequencer takes the slave modport; whoever drives the request takes the master modport.
interface slv_guard_rst_ctrl_if #(
    parameter int CntWidth = 8,
    parameter int EvtWidth = 8
);
    logic                guard_ena_i;
    logic                rst_req_i;
    logic [CntWidth-1:0] rst_len_i;
    logic                isolate_o;
    logic                slv_rst_no;
    logic                rst_stat_o;
    logic                busy_o;
    logic [EvtWidth-1:0] evt_cnt_o;

    modport master (
        output guard_ena_i, rst_req_i, rst_len_i,
        input  isolate_o, slv_rst_no, rst_stat_o, busy_o, evt_cnt_o
    );

    modport slave (
        input  guard_ena_i, rst_req_i, rst_len_i,
        output isolate_o, slv_rst_no, rst_stat_o, busy_o, evt_cnt_o
    );
endinterface

// File: rtl/slv_guard_rst_ctrl.sv
// Reset sequencer: isolate, hold subordinate reset, settle, then report completion.
// Outputs are decoded from registered state only; a started sequence always runs to DONE.
module slv_guard_rst_ctrl #(
    parameter int DrainCycles  = 4,
    parameter int SettleCycles = 2,
    parameter int CntWidth     = 8,
    parameter int EvtWidth     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    slv_guard_rst_ctrl_if.slave    bus
);

    if (DrainCycles < 1 || SettleCycles < 1 ||
        ((longint'(DrainCycles) - 1) >> CntWidth) != 0 ||
        ((longint'(SettleCycles) - 1) >> CntWidth) != 0) begin : g_bad_params
        $error("slv_guard_rst_ctrl: DrainCycles/SettleCycles out of range for CntWidth");
    end

    localparam logic [CntWidth-1:0] DRAIN_LD  = CntWidth'(DrainCycles - 1);
    localparam logic [CntWidth-1:0] SETTLE_LD = CntWidth'(SettleCycles - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISOLATE = 3'd1,
        ASSERT  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [EvtWidth-1:0] evt_q, evt_d;
    logic [CntWidth-1:0] len_ld;

    function automatic logic [EvtWidth-1:0] sat_inc(input logic [EvtWidth-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A zero length still produces a one-cycle reset pulse.
    assign len_ld = (bus.rst_len_i == '0) ? '0 : bus.rst_len_i - 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = evt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.rst_req_i && bus.guard_ena_i) begin
                    state_d = ISOLATE;
                    cnt_d   = DRAIN_LD;
                end
            end
            ISOLATE: begin
                if (cnt_q == '0) begin
                    state_d = ASSERT;
                    cnt_d   = len_ld;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = RELEASE;
                    cnt_d   = SETTLE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    evt_d   = sat_inc(evt_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (!bus.rst_req_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.isolate_o  = (state_q != IDLE);
    assign bus.slv_rst_no = (state_q != ASSERT);
    assign bus.rst_stat_o = (state_q == DONE);
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.evt_cnt_o  = evt_q;

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Directed bench for slv_guard_rst_ctrl (DrainCycles=4, SettleCycles=2, EvtWidth=2).
// Cycle k is the clock period following active edge k-1, where edge 0 samples the request.
module tb_slv_guard_rst_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    slv_guard_rst_ctrl_if #(.CntWidth(8), .EvtWidth(2)) bus ();

    slv_guard_rst_ctrl #(
        .DrainCycles (4),
        .SettleCycles(2),
        .CntWidth    (8),
        .EvtWidth    (2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // Packed view {isolate, slv_rst_n, stat, busy}; idle/reset value is 4'b0100.
    function automatic logic [3:0] outs();
        return {bus.isolate_o, bus.slv_rst_no, bus.rst_stat_o, bus.busy_o};
    endfunction

    typedef struct {
        logic [7:0] len;
        int         drop_cyc;   // cycle after which req/ena are dropped (0 = hold)
        int         lo_first;   // first cycle with slv_rst_no low
        int         lo_last;    // last cycle with slv_rst_no low
        int         stat_cyc;   // cycle in which rst_stat_o rises
        int         hold;       // extra DONE cycles with req kept high
        int         evt;        // expected evt_cnt_o at stat_cyc
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_row(input int id, input vec_t v);
        logic [3:0] exp;
        bus.rst_len_i   = v.len;
        bus.rst_req_i   = 1'b1;
        bus.guard_ena_i = 1'b1;
        for (int k = 1; k <= v.stat_cyc; k++) begin
            @(negedge clk);
            exp = {1'b1, !(k >= v.lo_first && k <= v.lo_last), (k == v.stat_cyc), 1'b1};
            check($sformatf("row%0d_cyc%0d", id, k), 32'(outs()), 32'(exp));
            if (k == v.drop_cyc) begin
                bus.rst_req_i   = 1'b0;
                bus.guard_ena_i = 1'b0;
            end
        end
        check($sformatf("row%0d_evt", id), 32'(bus.evt_cnt_o), 32'(v.evt));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check($sformatf("row%0d_done_hold%0d", id, h), 32'(outs()), 32'hF);
        end
        bus.rst_req_i   = 1'b0;
        bus.guard_ena_i = 1'b0;
        @(negedge clk);
        check($sformatf("row%0d_exit", id), 32'(outs()), 32'h4);
    endtask

    initial begin
        int n;
        bus.guard_ena_i = 1'b0;
        bus.rst_req_i   = 1'b0;
        bus.rst_len_i   = '0;

        //              len   drop lo_f lo_l stat hold evt
        vecs[0] = '{8'd8, 0,   5,   12,  15,  2,   2};  // basic sequence
        vecs[1] = '{8'd0, 0,   5,   5,   8,   0,   3};  // zero length -> 1 cycle
        vecs[2] = '{8'd1, 0,   5,   5,   8,   1,   3};  // saturated counter
        vecs[3] = '{8'd3, 3,   5,   7,   10,  0,   3};  // abort attempt at cycle 3

        repeat (3) @(negedge clk);
        check("reset_outs", 32'(outs()), 32'h4);
        check("reset_evt", 32'(bus.evt_cnt_o), 32'h0);
        rst = 1'b0;

        // Guard disabled: request ignored.
        bus.rst_req_i = 1'b1;
        bus.rst_len_i = 8'd2;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("guard_off_cyc%0d", k), 32'(outs()), 32'h4);
        end
        bus.guard_ena_i = 1'b1;
        @(negedge clk);
        check("guard_on_start", 32'(outs()), 32'hD);
        n = 1;
        while (!bus.rst_stat_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("guard_on_stat_cycle", 32'(n), 32'd9);
        check("guard_on_evt", 32'(bus.evt_cnt_o), 32'd1);
        bus.rst_req_i   = 1'b0;
        bus.guard_ena_i = 1'b0;
        @(negedge clk);
        check("guard_on_exit", 32'(outs()), 32'h4);

        for (int i = 0; i < 4; i++) run_row(i, vecs[i]);

        // Asynchronous reset while in ASSERT.
        bus.rst_len_i   = 8'd8;
        bus.rst_req_i   = 1'b1;
        bus.guard_ena_i = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_in_assert", 32'(outs()), 32'h9);
        rst = 1'b1;
        #1;
        check("midrst_outs", 32'(outs()), 32'h4);
        check("midrst_evt", 32'(bus.evt_cnt_o), 32'h0);
        bus.rst_req_i   = 1'b0;
        bus.guard_ena_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Five sequences saturate a 2-bit event counter.
        for (int s = 0; s < 5; s++) begin
            vec_t v;
            v = '{8'd1, 0, 5, 5, 8, 0, (s < 3) ? s + 1 : 3};
            run_row(10 + s, v);
        end
        check("sat_final_evt", 32'(bus.evt_cnt_o), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
